// File: rtl/dp_arbiter_if.sv
// Signal bundle between the instruction-issuing requesters, the arbiter and the
// shared datapath. The arbiter uses the slave view; the requester/datapath side uses master.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 32
`endif

interface dp_arbiter_if #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned INSTR_W  = `INSTRUCTION_WIDTH,
  parameter int unsigned RESULT_W = `RESULT_WIDTH
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_lock;
  logic [N_REQ*INSTR_W-1:0] req_instr;
  logic [N_REQ-1:0]         req_done;
  logic [RESULT_W-1:0]      req_result;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;
  logic                     start_dp;
  logic [INSTR_W-1:0]       instruction_dp;
  logic                     finished_dp;
  logic [RESULT_W-1:0]      result_dp;

  modport slave (
    input  req_valid, req_lock, req_instr, finished_dp, result_dp,
    output req_done, req_result, grant_id, busy, start_dp, instruction_dp
  );

  modport master (
    output req_valid, req_lock, req_instr, finished_dp, result_dp,
    input  req_done, req_result, grant_id, busy, start_dp, instruction_dp
  );
endinterface

// File: rtl/dp_arbiter.sv
// Round-robin arbiter sharing one datapath among N_REQ instruction issuers,
// with an optional per-owner lock that keeps the grant across back-to-back requests.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 32
`endif

module dp_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned INSTR_W  = `INSTRUCTION_WIDTH,
  parameter int unsigned RESULT_W = `RESULT_WIDTH
) (
  input  logic        clock,
  input  logic        resetn,
  dp_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                lock_hold_q, lock_hold_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [RESULT_W-1:0] result_q, result_d;

  logic [ID_W-1:0]     winner;
  logic                winner_ok;

  // Scanning the rotation backwards lets the nearest valid requester after
  // grant_id overwrite the farther ones, giving first-match without a break.
  always_comb begin : rr_select
    winner    = grant_id_q;
    winner_ok = 1'b0;
    if (lock_hold_q && bus.req_valid[grant_id_q]) begin
      winner_ok = 1'b1;
    end else begin
      for (int unsigned i = N_REQ; i >= 1; i--) begin
        if (bus.req_valid[ID_W'((32'(grant_id_q) + i) % N_REQ)]) begin
          winner    = ID_W'((32'(grant_id_q) + i) % N_REQ);
          winner_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    lock_hold_d = lock_hold_q;
    instr_d     = instr_q;
    result_d    = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (lock_hold_q && !bus.req_valid[grant_id_q]) begin
          lock_hold_d = 1'b0;
        end
        if (winner_ok) begin
          grant_id_d = winner;
          instr_d    = bus.req_instr[32'(winner)*INSTR_W +: INSTR_W];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE:  state_d = S_SETTLE;
      // finished_dp may still show the previous completion here.
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.finished_dp) begin
          result_d = bus.result_dp;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        lock_hold_d = bus.req_lock[grant_id_q];
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      grant_id_q  <= LAST_ID;
      lock_hold_q <= 1'b0;
      instr_q     <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      lock_hold_q <= lock_hold_d;
      instr_q     <= instr_d;
      result_q    <= result_d;
    end
  end

  assign bus.start_dp       = (state_q == S_ISSUE);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.req_done       = (state_q == S_DONE) ? (N_REQ'(1) << grant_id_q) : '0;
  assign bus.grant_id       = grant_id_q;
  assign bus.instruction_dp = instr_q;
  assign bus.req_result     = result_q;

endmodule

// File: doc/dp_arbiter.md
# dp_arbiter

Round-robin arbiter that shares the single drawing/compute datapath between up to `N_REQ` requester blocks (ant draw, screen clear, network evaluator, ...). Each requester presents one instruction at a time with a valid/done handshake. The arbiter issues the instruction to the datapath with a one-cycle `start_dp` pulse, waits for `finished_dp`, and returns `result_dp` to the owning requester. It sits between all instruction-issuing FSMs and the datapath and is the only driver of `start_dp` and `instruction_dp`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: width of requester index; must satisfy 2^ID_W >= N_REQ.
- `INSTR_W`, `` `INSTRUCTION_WIDTH `` (32): instruction width.
- `RESULT_W`, `` `RESULT_WIDTH `` (32): result width.

Ports:
- `clock`  in  1  system clock.
- `resetn`  in  1  synchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request, level.
- `req_lock`  in  N_REQ  per-requester "keep grant for my next request".
- `req_instr`  in  N_REQ*INSTR_W  packed instructions; requester i occupies bits [i*INSTR_W +: INSTR_W].
- `req_done`  out  N_REQ  one-cycle completion pulse to the owner.
- `req_result`  out  RESULT_W  shared result bus; valid in the `req_done` cycle and held until the next completion.
- `grant_id`  out  ID_W  index of the current or last owner.
- `busy`  out  1  high in every state except IDLE.
- `start_dp`  out  1  datapath start pulse.
- `instruction_dp`  out  INSTR_W  instruction to the datapath; registered.
- `finished_dp`  in  1  datapath idle/done.
- `result_dp`  in  RESULT_W  datapath result; valid while `finished_dp` is high after completion.

## Operation
- FSM states: IDLE, ISSUE, SETTLE, WAIT, DONE.
- **IDLE:** if any `req_valid` bit is set, select the winner and register `grant_id`. Latch `instruction_dp` from the winner's `req_instr` slice, then go to ISSUE. Otherwise stay in IDLE.
- **Winner selection:**
  - If `lock_hold` is set and `req_valid[grant_id]` is high, the winner is `grant_id`.
  - Otherwise, search round-robin starting at `grant_id+1` modulo N_REQ, wrapping, and take the first valid requester.
- **ISSUE:** `start_dp`=1 for exactly this cycle, then go to SETTLE.
- **SETTLE:** `start_dp`=0; `finished_dp` is ignored. Go to WAIT. This covers the datapath's one-cycle lag in dropping `finished_dp`.
- **WAIT:** stay until `finished_dp`=1. Then latch `result_dp` into `req_result` and go to DONE.
- **DONE:** `req_done[grant_id]`=1 for this cycle only. Set `lock_hold` to `req_lock[grant_id]` sampled this cycle. Go to IDLE.
- **Requester contract:**
  - Hold `req_instr` stable while `req_valid` is high.
  - Deassert `req_valid` on the edge after seeing `req_done`, unless issuing a new instruction.
  - Any `req_valid` still high in the IDLE cycle after DONE is treated as a new request.
- Requests arriving during a transaction are not lost. They are sampled in the next IDLE.
- A requester deasserting `req_valid` before being granted simply withdraws; no `req_done` is produced.
- `lock_hold` is cleared if the locked owner is not requesting in IDLE. Round-robin then resumes from that owner.
- `grant_id` is not an index outside 0..N_REQ-1. Invalid bits above N_REQ do not exist.

## Timing
- **Reset values:** `start_dp`=0, `instruction_dp`=0, `req_done`=0, `req_result`=0, `grant_id`=N_REQ-1 (so requester 0 wins first), `busy`=0, `lock_hold`=0, state=IDLE.
- **Reset mid-transaction:** return to IDLE next edge. No `req_done` is produced; the datapath shares `resetn`.
- **Latency:** `req_valid` seen in IDLE at cycle T gives:
  - `start_dp` at T+1;
  - SETTLE at T+2;
  - WAIT from T+3.
- If `finished_dp` is first sampled high at WAIT cycle W, then `req_done` and `req_result` are valid at W+1, and IDLE is at W+2.
- Minimum transaction is 5 cycles: IDLE→ISSUE→SETTLE→WAIT→DONE, with `finished_dp` high on the first WAIT cycle.
- `start_dp` is never high in two consecutive cycles. At most one `req_done` bit is high in any cycle.

## Test plan
- **Single request:** after reset, requester 2 sends 0x1003_0A05. The datapath holds `finished_dp` low for 3 cycles, then returns 0xDEAD.
  - `start_dp` high 1 cycle after the request, with `instruction_dp`=0x1003_0A05.
  - `req_done`=4'b0100 with `req_result`=0xDEAD exactly one cycle after `finished_dp` is seen.
- **Round-robin:** all 4 `req_valid` are held high continuously with distinct instructions. Grant order is 0,1,2,3,0. Exactly one `start_dp` per grant.
- **Lock:** requester 1 asserts `req_lock` and reissues 3 times while requester 3 is also requesting. Grants are 1,1,1, then 3 once `req_lock` drops.
- **Withdraw:** requester 0 raises then drops `req_valid` while requester 1 owns the datapath. Requester 0 receives no `req_done`, and no extra `start_dp` occurs.
- **Zero-wait datapath:** `finished_dp` is tied high except for one cycle after `start_dp`. The first transaction completes in 5 cycles, and SETTLE prevents completion in the ISSUE+1 cycle.
- **Reset in WAIT:** `resetn` is low for 1 cycle while in WAIT. All outputs return to reset values the next cycle, and no `req_done` pulse appears.
